// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C script/result buffer.
package i2c_pkg;

  localparam int SAW_DEF = 6;
  localparam int RAW_DEF = 5;

  // A zero length byte ends the script; also served once the script pointer overflows.
  localparam logic [7:0] TERM_BYTE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_BUSY,
    S_RUN,
    S_FINISH
  } state_e;

endpackage

// File: rtl/i2c_buf_ram.sv
// Single-write-port byte RAM with either combinational or registered read.
module i2c_buf_ram #(
  parameter int DW       = 8,
  parameter int AW       = 6,
  parameter bit REG_READ = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // NOTE: the storage array is deliberately not reset so it maps onto RAM rather than flops.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [DW-1:0] r_rdata;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else          r_rdata <= r_mem[i_raddr];
      end

      assign o_rdata = r_rdata;
    end else begin : g_async_read
      logic w_unused_rst;

      assign w_unused_rst = i_rst_n;
      assign o_rdata      = r_mem[i_raddr];
    end
  endgenerate

endmodule

// File: rtl/i2c_script_buf.sv
// Streams a CPU-written transaction script to the I2C master and captures its read-back bytes.
module i2c_script_buf
  import i2c_pkg::*;
#(
  parameter int SAW = SAW_DEF,
  parameter int RAW = RAW_DEF
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           SWE,
  input  logic [SAW-1:0] SADDR,
  input  logic [7:0]     SWDATA,
  input  logic [RAW-1:0] RADDR,
  output logic [7:0]     RDATA,
  input  logic           GO,
  output logic           RUNNING,
  output logic           DONE,
  output logic [RAW:0]   RCOUNT,
  output logic           SOVF,
  output logic           ROVF,
  output logic           M_START,
  input  logic           M_BUSY,
  output logic [7:0]     M_DATA_IN,
  input  logic           M_RD_ADV,
  input  logic           M_WR_ADV,
  input  logic [7:0]     M_DATA_OUT
);

  localparam logic [SAW-1:0] RPTR_LAST = '1;

  state_e         r_state, w_next;
  logic [SAW-1:0] r_rptr;
  logic [RAW:0]   r_wptr;
  logic           r_done, r_sovf, r_rovf;
  logic           w_start, w_idle, w_active, w_go, w_swe;
  logic           w_rd_adv, w_wr_adv, w_res_full, w_res_we;
  logic [7:0]     w_script_byte;

  assign w_idle     = (r_state == S_IDLE);
  assign w_active   = (r_state == S_WAIT_BUSY) || (r_state == S_RUN);
  assign w_go       = GO && w_idle;
  assign w_swe      = SWE && w_idle;
  assign w_rd_adv   = M_RD_ADV && w_active;
  assign w_wr_adv   = M_WR_ADV && w_active;
  assign w_res_full = r_wptr[RAW];
  assign w_res_we   = w_wr_adv && !w_res_full;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      S_IDLE:      if (w_go) w_next = S_ARM;
      S_ARM: begin
        w_start = 1'b1;
        w_next  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (M_BUSY) w_next = S_RUN;
      S_RUN:       if (!M_BUSY) w_next = S_FINISH;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Pointers and sticky flags; the overflowed read pointer parks on the last address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_done <= 1'b0;
      r_sovf <= 1'b0;
      r_rovf <= 1'b0;
    end else if (w_go) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_done <= 1'b0;
      r_sovf <= 1'b0;
      r_rovf <= 1'b0;
    end else begin
      if (w_rd_adv) begin
        if (r_rptr == RPTR_LAST) r_sovf <= 1'b1;
        else                     r_rptr <= r_rptr + SAW'(1);
      end
      if (w_wr_adv) begin
        if (w_res_full) r_rovf <= 1'b1;
        else            r_wptr <= r_wptr + (RAW + 1)'(1);
      end
      if (r_state == S_FINISH) r_done <= 1'b1;
    end
  end

  i2c_buf_ram #(.DW(8), .AW(SAW), .REG_READ(1'b0)) u_script_ram (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_we    (w_swe),
    .i_waddr (SADDR),
    .i_wdata (SWDATA),
    .i_raddr (r_rptr),
    .o_rdata (w_script_byte)
  );

  i2c_buf_ram #(.DW(8), .AW(RAW), .REG_READ(1'b1)) u_result_ram (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_we    (w_res_we),
    .i_waddr (r_wptr[RAW-1:0]),
    .i_wdata (M_DATA_OUT),
    .i_raddr (RADDR),
    .o_rdata (RDATA)
  );

  assign M_DATA_IN = r_sovf ? TERM_BYTE : w_script_byte;
  assign M_START   = w_start;
  assign RUNNING   = !w_idle;
  assign DONE      = r_done;
  assign RCOUNT    = r_wptr;
  assign SOVF      = r_sovf;
  assign ROVF      = r_rovf;

endmodule

// File: tb/tb_i2c_script_buf.sv
// Self-checking bench: a scripted I2C master model drives the buffer, a byte-level reference predicts results.
module tb_i2c_script_buf;

  localparam int SAW    = 6;
  localparam int RAW    = 5;
  localparam int SDEPTH = 64;
  localparam int RDEPTH = 32;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic           SWE = 1'b0;
  logic [SAW-1:0] SADDR = '0;
  logic [7:0]     SWDATA = 8'h00;
  logic [RAW-1:0] RADDR = '0;
  logic [7:0]     RDATA;
  logic           GO = 1'b0;
  logic           RUNNING, DONE, SOVF, ROVF, M_START;
  logic [RAW:0]   RCOUNT;
  logic           M_BUSY = 1'b0;
  logic [7:0]     M_DATA_IN;
  logic           M_RD_ADV = 1'b0;
  logic           M_WR_ADV = 1'b0;
  logic [7:0]     M_DATA_OUT = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;
  int start_seen;

  // Reference state: script image, result image, and per-run byte counts.
  logic [7:0]   m_script [SDEPTH];
  logic [7:0]   m_res [RDEPTH];
  bit           m_res_valid [RDEPTH];
  int           m_consumed;
  int           m_wcount;
  bit           m_rovf;
  byte unsigned sq[$];
  byte unsigned rd_q[$];

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  i2c_script_buf #(.SAW(SAW), .RAW(RAW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .SWE        (SWE),
    .SADDR      (SADDR),
    .SWDATA     (SWDATA),
    .RADDR      (RADDR),
    .RDATA      (RDATA),
    .GO         (GO),
    .RUNNING    (RUNNING),
    .DONE       (DONE),
    .RCOUNT     (RCOUNT),
    .SOVF       (SOVF),
    .ROVF       (ROVF),
    .M_START    (M_START),
    .M_BUSY     (M_BUSY),
    .M_DATA_IN  (M_DATA_IN),
    .M_RD_ADV   (M_RD_ADV),
    .M_WR_ADV   (M_WR_ADV),
    .M_DATA_OUT (M_DATA_OUT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (M_START === 1'b1) start_seen++;
  endtask

  // Byte the master should see after k advances: the script, then zeros once past the end.
  function automatic logic [7:0] byte_at(input int k);
    return (k < SDEPTH) ? m_script[k] : 8'h00;
  endfunction

  task automatic load_script();
    for (int i = 0; i < sq.size(); i++) begin
      SWE    = 1'b1;
      SADDR  = SAW'(i);
      SWDATA = sq[i];
      m_script[i] = sq[i];
      tick();
    end
    SWE = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    sq.push_back(b);
  endtask

  // Walk the script as the master would: bytes it consumes and read bytes it returns.
  task automatic plan(output int n_rd, output int n_wr);
    int k, len, wl;
    k    = 0;
    n_wr = 0;
    while (byte_at(k) != 8'h00 && k < 200) begin
      len = int'(byte_at(k));
      wl  = int'(byte_at(k + 1) & 8'h7f);
      k   = k + 2 + wl;
      if (len > wl) n_wr += len - wl;
    end
    n_rd = k;
  endtask

  task automatic check_results();
    for (int i = 0; i < RDEPTH; i++) begin
      if (m_res_valid[i]) begin
        RADDR = RAW'(i);
        tick();
        check($sformatf("rdata[%0d]", i), {24'h0, RDATA}, {24'h0, m_res[i]});
      end
    end
  endtask

  task automatic do_run(input bit inject, input int reset_after);
    int   rd_left, wr_left, cyc;
    bit   do_rd, do_wr;
    logic [7:0] d;
    plan(rd_left, wr_left);
    start_seen = 0;
    GO = 1'b1;
    tick();
    GO = 1'b0;
    m_consumed = 0;
    m_wcount   = 0;
    m_rovf     = 1'b0;
    check("m_start_after_go", {31'h0, M_START}, 32'd1);
    check("running_after_go", {31'h0, RUNNING}, 32'd1);
    check("done_clr_on_go",   {31'h0, DONE},    32'd0);
    check("rcount_clr_on_go", {26'h0, RCOUNT},  32'd0);
    tick();
    check("m_start_one_cycle", {31'h0, M_START}, 32'd0);
    repeat ($urandom_range(0, 2)) tick();
    M_BUSY = 1'b1;
    tick();
    if (inject) begin
      SWE = 1'b1; SADDR = '0; SWDATA = ~m_script[0]; GO = 1'b1;
      tick();
      SWE = 1'b0; GO = 1'b0;
      check("running_after_inject", {31'h0, RUNNING}, 32'd1);
    end
    cyc = 0;
    while (rd_left > 0 || wr_left > 0) begin
      if (cyc == reset_after) begin
        RESET_N = 1'b0;
        M_RD_ADV = 1'b0; M_WR_ADV = 1'b0; M_BUSY = 1'b0;
        #1;
        check("rst_running", {31'h0, RUNNING}, 32'd0);
        check("rst_done",    {31'h0, DONE},    32'd0);
        check("rst_sovf",    {31'h0, SOVF},    32'd0);
        check("rst_rovf",    {31'h0, ROVF},    32'd0);
        check("rst_m_start", {31'h0, M_START}, 32'd0);
        check("rst_rcount",  {26'h0, RCOUNT},  32'd0);
        check("rst_rdata",   {24'h0, RDATA},   32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        m_consumed = 0; m_wcount = 0; m_rovf = 1'b0;
        tick();
        check("post_rst_m_data_in", {24'h0, M_DATA_IN}, {24'h0, m_script[0]});
        check("post_rst_running",   {31'h0, RUNNING},   32'd0);
        return;
      end
      do_rd = (rd_left > 0) && ($urandom_range(0, 1) == 1);
      do_wr = (wr_left > 0) && ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      if (do_wr && rd_q.size() > 0) d = rd_q.pop_front();
      if (do_rd) check($sformatf("m_data_in@%0d", m_consumed), {24'h0, M_DATA_IN}, {24'h0, byte_at(m_consumed)});
      M_RD_ADV = do_rd; M_WR_ADV = do_wr; M_DATA_OUT = d;
      tick();
      M_RD_ADV = 1'b0; M_WR_ADV = 1'b0;
      if (do_rd) begin
        m_consumed++;
        rd_left--;
      end
      if (do_wr) begin
        if (m_wcount < RDEPTH) begin
          m_res[m_wcount] = d;
          m_res_valid[m_wcount] = 1'b1;
          m_wcount++;
        end else begin
          m_rovf = 1'b1;
        end
        wr_left--;
      end
      check("done_low_in_run", {31'h0, DONE}, 32'd0);
      cyc++;
    end
    check("m_data_in_term", {24'h0, M_DATA_IN}, {24'h0, byte_at(m_consumed)});
    M_BUSY = 1'b0;
    tick();
    check("running_finish", {31'h0, RUNNING}, 32'd1);
    check("done_finish",    {31'h0, DONE},    32'd0);
    tick();
    check("running_end", {31'h0, RUNNING}, 32'd0);
    check("done_end",    {31'h0, DONE},    32'd1);
    check("rcount_end",  {26'h0, RCOUNT},  32'(m_wcount));
    check("sovf_end",    {31'h0, SOVF},    {31'h0, (m_consumed >= SDEPTH)});
    check("rovf_end",    {31'h0, ROVF},    {31'h0, m_rovf});
    check("m_start_pulses", 32'(start_seen), 32'd1);
  endtask

  initial begin
    int n;
    int len, wl;
    for (int i = 0; i < RDEPTH; i++) m_res_valid[i] = 1'b0;
    start_seen = 0;

    #12;
    check("reset_running", {31'h0, RUNNING}, 32'd0);
    check("reset_done",    {31'h0, DONE},    32'd0);
    check("reset_sovf",    {31'h0, SOVF},    32'd0);
    check("reset_rovf",    {31'h0, ROVF},    32'd0);
    check("reset_m_start", {31'h0, M_START}, 32'd0);
    check("reset_rcount",  {26'h0, RCOUNT},  32'd0);
    check("reset_rdata",   {24'h0, RDATA},   32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();

    sq.delete();
    for (int i = 0; i < SDEPTH; i++) push(8'($urandom));
    load_script();
    check("m_data_in_after_swe", {24'h0, M_DATA_IN}, {24'h0, m_script[0]});

    // Write-only transaction.
    sq.delete();
    push(8'h02); push(8'h02); push(8'hA0); push(8'h10); push(8'h00);
    load_script();
    do_run(1'b0, -1);

    // Read transaction with two fixed return bytes.
    sq.delete();
    push(8'h03); push(8'h81); push(8'hD1); push(8'h00);
    load_script();
    rd_q.push_back(8'h5A); rd_q.push_back(8'hC3);
    do_run(1'b0, -1);
    check_results();

    // Two transactions in one run, with SWE and GO attempted mid-run, then rerun unchanged.
    sq.delete();
    push(8'h02); push(8'h02); push(8'hA0); push(8'h10);
    push(8'h03); push(8'h81); push(8'hD1); push(8'h00);
    load_script();
    do_run(1'b1, -1);
    do_run(1'b0, -1);
    check_results();

    // Script fills every address with no terminator.
    sq.delete();
    push(8'h3E); push(8'h3E);
    for (int i = 0; i < 62; i++) push(8'($urandom));
    load_script();
    do_run(1'b0, -1);

    // 33 read bytes into a 32-byte result RAM.
    sq.delete();
    push(8'h21); push(8'h00); push(8'h00);
    load_script();
    do_run(1'b0, -1);
    check_results();

    // Random scripts.
    repeat (4) begin
      sq.delete();
      n = $urandom_range(1, 4);
      repeat (n) begin
        len = $urandom_range(1, 6);
        wl  = $urandom_range(0, len);
        push(8'(len));
        push({1'($urandom), 7'(wl)});
        repeat (wl) push(8'($urandom));
      end
      push(8'h00);
      load_script();
      do_run(1'b0, -1);
      check_results();
    end

    // Reset in the middle of a read-heavy run.
    sq.delete();
    push(8'h21); push(8'h00); push(8'h00);
    load_script();
    do_run(1'b0, 10);
    check_results();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
